// File: rtl/clk_div_multi_if.sv
// Bundles the per-channel enables, config write port, sync strobe and divider outputs of
// clk_div_multi.
interface clk_div_multi_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 8
);
  logic [NUM_CH-1:0] ch_en;
  logic              cfg_wr;
  logic [3:0]        cfg_ch;
  logic [CNT_W-1:0]  cfg_div;
  logic [CNT_W-1:0]  cfg_high;
  logic              sync;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] cfg_pend;

  modport master (
    output ch_en, cfg_wr, cfg_ch, cfg_div, cfg_high, sync,
    input  clk_out, tick, cfg_pend
  );

  modport slave (
    input  ch_en, cfg_wr, cfg_ch, cfg_div, cfg_high, sync,
    output clk_out, tick, cfg_pend
  );
endinterface

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider; config changes land only on period boundaries.
// Define CLK_DIV_SYNC_EN to let the sync strobe force all running channels through a boundary.
module clk_div_multi #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 8
) (
  input logic            clk,
  input logic            rst,
  clk_div_multi_if.slave bus
);

  logic [CNT_W-1:0]  cnt_q    [NUM_CH];
  logic [CNT_W-1:0]  cnt_d    [NUM_CH];
  logic [CNT_W-1:0]  div_a_q  [NUM_CH];
  logic [CNT_W-1:0]  div_a_d  [NUM_CH];
  logic [CNT_W-1:0]  high_a_q [NUM_CH];
  logic [CNT_W-1:0]  high_a_d [NUM_CH];
  logic [CNT_W-1:0]  div_p_q  [NUM_CH];
  logic [CNT_W-1:0]  div_p_d  [NUM_CH];
  logic [CNT_W-1:0]  high_p_q [NUM_CH];
  logic [CNT_W-1:0]  high_p_d [NUM_CH];
  logic [NUM_CH-1:0] run_q, run_d;
  logic [NUM_CH-1:0] pend_q, pend_d;
  logic [NUM_CH-1:0] clk_q, clk_d;
  logic [NUM_CH-1:0] tick_q, tick_d;

  logic              sync_hit;
  logic              wr_hit;
  logic              bound;
  logic [CNT_W-1:0]  div_eff;

`ifdef CLK_DIV_SYNC_EN
  assign sync_hit = bus.sync;
`else
  assign sync_hit = 1'b0;
`endif

  always_comb begin
    wr_hit  = 1'b0;
    bound   = 1'b0;
    div_eff = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      // Out-of-range channel indices never match, so such writes are dropped.
      wr_hit      = bus.cfg_wr && (int'(bus.cfg_ch) == i);
      div_p_d[i]  = wr_hit ? bus.cfg_div  : div_p_q[i];
      high_p_d[i] = wr_hit ? bus.cfg_high : high_p_q[i];
      pend_d[i]   = pend_q[i] | wr_hit;
      run_d[i]    = run_q[i];
      cnt_d[i]    = cnt_q[i];
      div_a_d[i]  = div_a_q[i];
      high_a_d[i] = high_a_q[i];
      clk_d[i]    = 1'b0;
      tick_d[i]   = 1'b0;
      div_eff     = (div_a_q[i] == '0) ? CNT_W'(1) : div_a_q[i];
      if (!bus.ch_en[i]) begin
        run_d[i] = 1'b0;
        cnt_d[i] = '0;
      end else begin
        // A start from stopped is handled exactly like a period boundary.
        bound    = !run_q[i] || sync_hit || (cnt_q[i] == div_eff);
        run_d[i] = 1'b1;
        if (bound) begin
          cnt_d[i]    = '0;
          div_a_d[i]  = div_p_q[i];
          high_a_d[i] = high_p_q[i];
          pend_d[i]   = wr_hit;
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
        clk_d[i]  = cnt_d[i] < high_a_d[i];
        tick_d[i] = (cnt_d[i] == '0);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i]    <= '0;
        div_a_q[i]  <= '0;
        high_a_q[i] <= '0;
        div_p_q[i]  <= '0;
        high_p_q[i] <= '0;
      end
      run_q  <= '0;
      pend_q <= '0;
      clk_q  <= '0;
      tick_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i]    <= cnt_d[i];
        div_a_q[i]  <= div_a_d[i];
        high_a_q[i] <= high_a_d[i];
        div_p_q[i]  <= div_p_d[i];
        high_p_q[i] <= high_p_d[i];
      end
      run_q  <= run_d;
      pend_q <= pend_d;
      clk_q  <= clk_d;
      tick_q <= tick_d;
    end
  end

  assign bus.clk_out  = clk_q;
  assign bus.tick     = tick_q;
  assign bus.cfg_pend = pend_q;

endmodule

// File: doc/clk_div_multi.md
CLK_DIV_MULTI -- requirements
Module: clk_div_multi

Interface
REQ-001 Parameter NUM_CH, default 4: number of independent divider channels (1..16).
REQ-002 Parameter CNT_W, default 8: width of period/high-time counters and config fields (2..16).
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 ch_en  input  NUM_CH  per-channel run enable, level sensitive.
REQ-006 cfg_wr  input  1  one-cycle config write strobe.
REQ-007 cfg_ch  input  4  target channel index for cfg_wr.
REQ-008 cfg_div  input  CNT_W  period minus one (period = cfg_div+1 cycles).
REQ-009 cfg_high  input  CNT_W  high time in cycles within the period.
REQ-010 sync  input  1  phase-realign strobe (active only with CLK_DIV_SYNC_EN).
REQ-011 clk_out  output  NUM_CH  registered divided clocks.
REQ-012 tick  output  NUM_CH  registered one-cycle pulse at start of each period.
REQ-013 cfg_pend  output  NUM_CH  written config waiting for the next period boundary.

Function
REQ-014 Each channel SHALL hold pending regs (div_p, high_p), active regs (div_a, high_a) and counter cnt, all CNT_W bits.
REQ-015 cfg_wr with cfg_ch < NUM_CH SHALL load div_p/high_p of that channel and set its cfg_pend on the same edge; cfg_ch >= NUM_CH SHALL be ignored.
REQ-016 Multiple writes to a channel before its boundary: last write wins.
REQ-017 Stopped state (ch_en=0): cnt=0, clk_out=0, tick=0; cfg_pend and pending regs retained.
REQ-018 Start: edge where ch_en=1 and channel stopped SHALL set cnt=0, copy pending to active, clear cfg_pend, drive clk_out=(high_p!=0), tick=1.
REQ-019 Running: cnt increments each edge; edge where cnt==div_a SHALL wrap cnt to 0 (period boundary).
REQ-020 At a period boundary, pending SHALL be copied to active and cfg_pend cleared; never mid-period (no runt pulses).
REQ-021 cfg_wr to a channel on the same edge as its boundary SHALL NOT be applied at that boundary; it applies at the next one and cfg_pend stays 1.
REQ-022 clk_out SHALL equal (cnt_next < high_next), registered on the same edge as cnt, using post-boundary active values.
REQ-023 high_a=0: clk_out constantly 0; high_a > div_a: clk_out constantly 1; tick still generated.
REQ-024 div_a=0 SHALL be treated as 1 (minimum period 2 cycles).
REQ-025 tick SHALL be 1 exactly in cycles where running and cnt==0.
REQ-026 ch_en falling SHALL enter stopped state on the next edge, regardless of cnt (immediate stop).
REQ-027 Channels SHALL be fully independent except for sync.

Reset
REQ-028 rst=1 SHALL asynchronously clear cnt, active and pending regs, cfg_pend, clk_out and tick on all channels.
REQ-029 After rst release with ch_en=1, channels SHALL start per REQ-018 on the first edge, using all-zero config (period 2, clk_out low).

Configuration
REQ-030 Macro CLK_DIV_SYNC_EN: when defined, sync=1 on an edge SHALL force every running channel through a boundary (cnt=0, pending applied, tick=1, clk_out=(high!=0)); sync beats a simultaneous natural wrap.
REQ-031 Without CLK_DIV_SYNC_EN, the sync port SHALL exist and be ignored; no sync logic synthesised.

Verification
REQ-032 NUM_CH=4, ch0 div=3 high=2, enable -> clk_out[0] 1,1,0,0 repeating; tick every 4th cycle.
REQ-033 ch1 running div=3 high=2; write div=5 high=3 mid-period -> current period finishes as 4 cycles, then 6-cycle periods high 3; cfg_pend high until boundary.
REQ-034 Write on the exact wrap edge -> old config runs one more period; write to cfg_ch=7 -> no channel changes.
REQ-035 high=0 -> clk_out stuck 0; high=9 with div=3 -> stuck 1; div=0 -> period 2.
REQ-036 Assert rst mid-period -> all outputs 0 immediately, no clock edge needed; drop ch_en mid-period -> clk_out 0 next edge.
REQ-037 With CLK_DIV_SYNC_EN, ch0 div=3, ch1 div=5, pulse sync -> both tick next cycle, aligned; without macro, sync has no effect.
